pll_dyn_ctrl: RTL
=================

# pll_dyn_ctrl

Sequencer driving the dynamic charge-pump and loop-filter controls and the reset of the Gowin PLL wrapper, and qualifying its lock output. Runs on the free-running board clock, not on any PLL output. Applies a loop setting, pulses PLL reset, waits for a stable lock with timeout and bounded retry, and reports status to the clock/reset tree. Software or board logic can request new settings through a valid/ready handshake.

## Interface
- RST_CYCLES, 32: cycles pll_reset is held high per attempt (≥1)
- LOCK_STABLE, 1024: consecutive synced-lock-high cycles required before `locked` asserts
- LOCK_TIMEOUT, 65536: WAIT_LOCK cycles allowed per attempt
- MAX_RETRY, 3: attempts before FAIL (≥1)
- DEF_ICP 6'd20, DEF_RES 3'd2, DEF_CAP 2'd0: settings applied out of reset
- clk  in  1  board clock; one clock domain
- reset  in  1  synchronous, active-high
- cfg_valid  in  1  new-setting request
- cfg_ready  out  1  request accepted when both high
- cfg_icp / cfg_res / cfg_cap  in  6 / 3 / 2  requested settings
- icpsel / lpfres / lpfcap  out  6 / 3 / 2  to PLL dynamic inputs
- pll_reset  out  1  to PLL reset
- pll_lock  in  1  PLL lock, asynchronous to clk
- locked  out  1  qualified lock
- fail  out  1  all attempts exhausted
- retry_cnt  out  2  attempts consumed in current sequence (saturating)
- loss_cnt  out  8  lock-loss events since reset (saturating at 255)

## Operation
- pll_lock passes a 2-flop synchronizer; all decisions use the synced value (`lk`).
- States: HOLD, WAIT_LOCK, LOCKED, FAIL.
- HOLD: pll_reset=1; counter runs RST_CYCLES cycles, then WAIT_LOCK.
- WAIT_LOCK: pll_reset=0; stable counter increments while lk=1, clears on lk=0; timeout counter increments every cycle. Stable reaching LOCK_STABLE → LOCKED (takes priority over a simultaneous timeout). Timeout reaching LOCK_TIMEOUT → retry_cnt+1; if new value = MAX_RETRY → FAIL, else HOLD.
- LOCKED: locked=1, cfg_ready=1. lk=0 for one cycle → loss_cnt+1, retry_cnt←0, locked←0, then relock behaviour per Configuration.
- FAIL: fail=1, pll_reset=1, cfg_ready=1.
- Accept (cfg_valid & cfg_ready): icpsel/lpfres/lpfcap take cfg values, retry_cnt←0, fail←0, locked←0, state→HOLD, all on the same edge. Accept has priority over a lock loss in the same cycle.
- cfg inputs are ignored outside LOCKED/FAIL; cfg_ready=0 in HOLD/WAIT_LOCK.
- Counter widths are $clog2 of their limit plus 1; no wrap occurs because every counter clears on state entry.

## Timing
- Reset values: state HOLD, pll_reset=1, icpsel=DEF_ICP, lpfres=DEF_RES, lpfcap=DEF_CAP, locked=0, fail=0, cfg_ready=0, retry_cnt=0, loss_cnt=0, synchronizer flops 0.
- Reset asserted mid-sequence aborts immediately. The next cycle matches the reset values, and any latched cfg is discarded.
- All outputs are registered. pll_reset is high for exactly RST_CYCLES cycles per attempt.
- Minimum lock latency after HOLD exits = 2 (sync) + LOCK_STABLE cycles.
- Lock-loss detection = 2 sync cycles + 1 cycle: locked falls 3 cycles after pll_lock falls.

## Configuration
- PLL_DYN_CTRL_RELOCK_EN defined: lock loss in LOCKED → HOLD with the current settings, starting a fresh retry sequence.
- Not defined: lock loss → FAIL directly (pll_reset=1, fail=1), and only a new cfg accept or reset restarts the sequence.
- loss_cnt counts in both builds.

## Structure
- Package pll_dyn_pkg: state enum, default ICP/RES/CAP constants, width constants 6/3/2.
- One sub-module, sync_2ff, for the lock synchronizer (reusable elsewhere). The FSM and counters stay in pll_dyn_ctrl.

## Test plan
Bench parameters: RST_CYCLES=4, LOCK_STABLE=8, LOCK_TIMEOUT=64, MAX_RETRY=2.
- Power-up, pll_lock rises 10 cycles after pll_reset falls → pll_reset high 4 cycles, outputs 20/2/0, locked rises 10+2+8 cycles after pll_reset falls, retry_cnt=0.
- pll_lock never rises → two 4-cycle reset pulses separated by 64-cycle waits, retry_cnt=1 then 2, fail=1, pll_reset held 1, cfg_ready=1.
- In FAIL, cfg 33/5/1 accepted, then lock → outputs 33/5/1 on the accept edge, fail=0, lock sequence completes, locked=1.
- In LOCKED, pll_lock low 1 cycle → locked falls 3 cycles later, loss_cnt=1. With RELOCK_EN, 4-cycle reset pulse then relock. Without it, fail=1.
- pll_lock toggles every 5 cycles in WAIT_LOCK → never locks, timeout after 64 cycles.
- Reset asserted during WAIT_LOCK after a cfg change → next cycle outputs 20/2/0, pll_reset=1, counters 0.

Source files
------------

// File: rtl/pll_dyn_pkg.sv
// Shared constants and state encoding for the PLL dynamic-control sequencer.
package pll_dyn_pkg;

  localparam int ICP_W = 6;
  localparam int RES_W = 3;
  localparam int CAP_W = 2;

  localparam logic [ICP_W-1:0] PLL_DEF_ICP = 6'd20;
  localparam logic [RES_W-1:0] PLL_DEF_RES = 3'd2;
  localparam logic [CAP_W-1:0] PLL_DEF_CAP = 2'd0;

  typedef logic [1:0] state_t;

  localparam state_t ST_HOLD      = 2'd0;
  localparam state_t ST_WAIT_LOCK = 2'd1;
  localparam state_t ST_LOCKED    = 2'd2;
  localparam state_t ST_FAIL      = 2'd3;

endpackage

// File: rtl/pll_dyn_ctrl_if.sv
// Valid/ready request bus carrying new charge-pump / loop-filter settings.
interface pll_dyn_ctrl_if;
  import pll_dyn_pkg::*;

  logic             cfg_valid;
  logic             cfg_ready;
  logic [ICP_W-1:0] cfg_icp;
  logic [RES_W-1:0] cfg_res;
  logic [CAP_W-1:0] cfg_cap;

  modport master (output cfg_valid, cfg_icp, cfg_res, cfg_cap, input cfg_ready);
  modport slave  (input cfg_valid, cfg_icp, cfg_res, cfg_cap, output cfg_ready);

endinterface

// File: rtl/pll_dyn_ctrl_sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level; clears to 0 on reset.
module sync_2ff (
  input  logic clk,
  input  logic reset,
  input  logic d_i,
  output logic q_o
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;

  always_comb begin
    meta_d = d_i;
    sync_d = meta_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/pll_dyn_ctrl.sv
// PLL reset/lock sequencer with dynamic ICP/LPF settings, timeout and bounded retry.
// Optional: define PLL_DYN_CTRL_RELOCK_EN to re-run the sequence after a lock loss.
module pll_dyn_ctrl
  import pll_dyn_pkg::*;
#(
  parameter int               RST_CYCLES   = 32,
  parameter int               LOCK_STABLE  = 1024,
  parameter int               LOCK_TIMEOUT = 65536,
  parameter int               MAX_RETRY    = 3,
  parameter logic [ICP_W-1:0] DEF_ICP      = PLL_DEF_ICP,
  parameter logic [RES_W-1:0] DEF_RES      = PLL_DEF_RES,
  parameter logic [CAP_W-1:0] DEF_CAP      = PLL_DEF_CAP
) (
  input  logic              clk,
  input  logic              reset,
  pll_dyn_ctrl_if.slave     cfg,
  output logic [ICP_W-1:0]  icpsel,
  output logic [RES_W-1:0]  lpfres,
  output logic [CAP_W-1:0]  lpfcap,
  output logic              pll_reset,
  input  logic              pll_lock,
  output logic              locked,
  output logic              fail,
  output logic [1:0]        retry_cnt,
  output logic [7:0]        loss_cnt
);

  localparam int HOLD_W = $clog2(RST_CYCLES) + 1;
  localparam int STAB_W = $clog2(LOCK_STABLE) + 1;
  localparam int TMO_W  = $clog2(LOCK_TIMEOUT) + 1;

  logic lk;

  sync_2ff u_lock_sync (
    .clk   (clk),
    .reset (reset),
    .d_i   (pll_lock),
    .q_o   (lk)
  );

  state_t             state_q, state_d;
  logic [HOLD_W-1:0]  hold_q, hold_d;
  logic [STAB_W-1:0]  stab_q, stab_d;
  logic [TMO_W-1:0]   tmo_q, tmo_d;
  logic [1:0]         retry_q, retry_d;
  logic [7:0]         loss_q, loss_d;
  logic [ICP_W-1:0]   icp_q, icp_d;
  logic [RES_W-1:0]   res_q, res_d;
  logic [CAP_W-1:0]   cap_q, cap_d;
  logic               pll_reset_q, pll_reset_d;
  logic               locked_q, locked_d;
  logic               fail_q, fail_d;
  logic               cfg_ready_q, cfg_ready_d;
  logic               accept;

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    stab_d  = stab_q;
    tmo_d   = tmo_q;
    retry_d = retry_q;
    loss_d  = loss_q;
    icp_d   = icp_q;
    res_d   = res_q;
    cap_d   = cap_q;
    accept  = cfg.cfg_valid & cfg_ready_q;

    case (state_q)
      ST_HOLD: begin
        if (hold_q == HOLD_W'(RST_CYCLES - 1)) state_d = ST_WAIT_LOCK;
        else                                   hold_d  = hold_q + 1'b1;
      end
      ST_WAIT_LOCK: begin
        stab_d = lk ? stab_q + 1'b1 : '0;
        tmo_d  = tmo_q + 1'b1;
        // A stable lock on the same cycle as the timeout still counts as locked.
        if (stab_d == STAB_W'(LOCK_STABLE)) begin
          state_d = ST_LOCKED;
        end else if (tmo_d == TMO_W'(LOCK_TIMEOUT)) begin
          retry_d = (retry_q == 2'd3) ? retry_q : retry_q + 2'd1;
          state_d = (int'(retry_q) + 1 >= MAX_RETRY) ? ST_FAIL : ST_HOLD;
        end
      end
      ST_LOCKED: begin
        if (!lk) begin
          loss_d  = (loss_q == 8'hFF) ? loss_q : loss_q + 8'd1;
          retry_d = '0;
`ifdef PLL_DYN_CTRL_RELOCK_EN
          state_d = ST_HOLD;
`else
          state_d = ST_FAIL;
`endif
        end
      end
      default: ;
    endcase

    if (accept) begin
      icp_d   = cfg.cfg_icp;
      res_d   = cfg.cfg_res;
      cap_d   = cfg.cfg_cap;
      retry_d = '0;
      loss_d  = loss_q;
      state_d = ST_HOLD;
    end

    // Every phase counts from zero, so the counters never need to wrap.
    if (accept || (state_d != state_q)) begin
      hold_d = '0;
      stab_d = '0;
      tmo_d  = '0;
    end

    pll_reset_d = (state_d == ST_HOLD) || (state_d == ST_FAIL);
    locked_d    = (state_d == ST_LOCKED);
    fail_d      = (state_d == ST_FAIL);
    cfg_ready_d = (state_d == ST_LOCKED) || (state_d == ST_FAIL);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_HOLD;
      hold_q      <= '0;
      stab_q      <= '0;
      tmo_q       <= '0;
      retry_q     <= '0;
      loss_q      <= '0;
      icp_q       <= DEF_ICP;
      res_q       <= DEF_RES;
      cap_q       <= DEF_CAP;
      pll_reset_q <= 1'b1;
      locked_q    <= 1'b0;
      fail_q      <= 1'b0;
      cfg_ready_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      hold_q      <= hold_d;
      stab_q      <= stab_d;
      tmo_q       <= tmo_d;
      retry_q     <= retry_d;
      loss_q      <= loss_d;
      icp_q       <= icp_d;
      res_q       <= res_d;
      cap_q       <= cap_d;
      pll_reset_q <= pll_reset_d;
      locked_q    <= locked_d;
      fail_q      <= fail_d;
      cfg_ready_q <= cfg_ready_d;
    end
  end

  assign cfg.cfg_ready = cfg_ready_q;
  assign icpsel        = icp_q;
  assign lpfres        = res_q;
  assign lpfcap        = cap_q;
  assign pll_reset     = pll_reset_q;
  assign locked        = locked_q;
  assign fail          = fail_q;
  assign retry_cnt     = retry_q;
  assign loss_cnt      = loss_q;

endmodule
